// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, FSM state
// encodings, ALU operation codes, mux-select codes and the control word.
// Build option: MC_ADDI_SUPPORT_EN adds the addi instruction to the legal set.
package mips_pkg;

  // Instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // alu_control operation selects
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-operand selects
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // FSM state encodings (4 bits; the controller widens them to STATE_W)
  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADR  = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_RTYPEEX = 4'd6;
  localparam logic [3:0] ST_RTYPEWB = 4'd7;
  localparam logic [3:0] ST_BEQEX   = 4'd8;
  localparam logic [3:0] ST_ADDIEX  = 4'd9;
  localparam logic [3:0] ST_ADDIWB  = 4'd10;
  localparam logic [3:0] ST_JEX     = 4'd11;

  // One cycle's worth of datapath control
  typedef struct packed {
    logic       mem_req;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       illegal_op;
    logic       i_or_d;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // True for every opcode the controller knows how to execute
  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
            (op == OP_BEQ) || (op == OP_J);
`ifdef MC_ADDI_SUPPORT_EN
    legal = legal || (op == OP_ADDI);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller-to-datapath bundle: opcode and memory handshake in, control
// strobes and mux selects out. The controller uses the master view.
interface mc_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       branch;
  logic       illegal_op;
  logic       i_or_d;
  logic       alu_src_a;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;

  modport master (
    input  op, mem_ready,
    output mem_req, ir_write, pc_write, reg_write, mem_write, branch,
           illegal_op, i_or_d, alu_src_a, reg_dst, mem_to_reg,
           alu_src_b, alu_op, pc_src
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, ir_write, pc_write, reg_write, mem_write, branch,
           illegal_op, i_or_d, alu_src_a, reg_dst, mem_to_reg,
           alu_src_b, alu_op, pc_src
  );
endinterface

// File: rtl/mc_output_decode.sv
// State-to-control-word decode for the multicycle controller. Outputs are a
// function of state only, except the FETCH strobes (qualified by mem_ready),
// the DECODE illegal-opcode flag, and the reset override.
// Build option: MC_ADDI_SUPPORT_EN adds the ADDIEX/ADDIWB decodes.
module mc_output_decode
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output ctrl_t              ctrl
);

  localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(ST_FETCH);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(ST_DECODE);
  localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(ST_MEMADR);
  localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(ST_MEMRD);
  localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(ST_MEMWB);
  localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(ST_MEMWR);
  localparam logic [STATE_W-1:0] S_RTYPEEX = STATE_W'(ST_RTYPEEX);
  localparam logic [STATE_W-1:0] S_RTYPEWB = STATE_W'(ST_RTYPEWB);
  localparam logic [STATE_W-1:0] S_BEQEX   = STATE_W'(ST_BEQEX);
  localparam logic [STATE_W-1:0] S_JEX     = STATE_W'(ST_JEX);
`ifdef MC_ADDI_SUPPORT_EN
  localparam logic [STATE_W-1:0] S_ADDIEX  = STATE_W'(ST_ADDIEX);
  localparam logic [STATE_W-1:0] S_ADDIWB  = STATE_W'(ST_ADDIWB);
`endif

  // Per-state control word; reset shows the FETCH selects with all strobes low
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = ALUB_IMMSH;
        ctrl.illegal_op = !op_is_legal(op);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_BRANCH;
        ctrl.branch    = 1'b1;
      end
`ifdef MC_ADDI_SUPPORT_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      S_JEX: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ctrl           = '0;
      ctrl.alu_src_b = ALUB_FOUR;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main controller: Moore FSM with memory-ready stalls in
// FETCH, MEMRD and MEMWR. Next-state logic and the state register live here;
// the control word comes from mc_output_decode.
// Build option: MC_ADDI_SUPPORT_EN enables the addi path (ADDIEX/ADDIWB);
// without it, addi is treated as an illegal opcode.
module mc_control
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(ST_FETCH);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(ST_DECODE);
  localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(ST_MEMADR);
  localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(ST_MEMRD);
  localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(ST_MEMWB);
  localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(ST_MEMWR);
  localparam logic [STATE_W-1:0] S_RTYPEEX = STATE_W'(ST_RTYPEEX);
  localparam logic [STATE_W-1:0] S_RTYPEWB = STATE_W'(ST_RTYPEWB);
  localparam logic [STATE_W-1:0] S_BEQEX   = STATE_W'(ST_BEQEX);
  localparam logic [STATE_W-1:0] S_JEX     = STATE_W'(ST_JEX);
`ifdef MC_ADDI_SUPPORT_EN
  localparam logic [STATE_W-1:0] S_ADDIEX  = STATE_W'(ST_ADDIEX);
  localparam logic [STATE_W-1:0] S_ADDIWB  = STATE_W'(ST_ADDIWB);
`endif

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  ctrl_t              ctrl;

  // Next state; op is only looked at in DECODE and MEMADR
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:   if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_RTYPEEX;
          OP_BEQ:       state_nxt = S_BEQEX;
`ifdef MC_ADDI_SUPPORT_EN
          OP_ADDI:      state_nxt = S_ADDIEX;
`endif
          OP_J:         state_nxt = S_JEX;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  state_nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.mem_ready) state_nxt = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) state_nxt = S_FETCH;
      S_RTYPEEX: state_nxt = S_RTYPEWB;
`ifdef MC_ADDI_SUPPORT_EN
      S_ADDIEX:  state_nxt = S_ADDIWB;
`endif
      default:   state_nxt = S_FETCH;
    endcase
  end

  // State register; reset returns to FETCH from anywhere, including stalls
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  mc_output_decode #(
    .STATE_W (STATE_W)
  ) u_decode (
    .reset     (reset),
    .state     (state),
    .op        (bus.op),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.mem_req    = ctrl.mem_req;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.pc_write   = ctrl.pc_write;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.branch     = ctrl.branch;
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: directed instruction sequences with literal
// expectations, then randomized opcode/mem_ready/reset traffic compared every
// cycle against an instruction-level model. Honors MC_ADDI_SUPPORT_EN.
module tb_mc_control;

  localparam logic [5:0] T_RT   = 6'b000000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BAD  = 6'b111111;

  // Instruction steps the model walks through
  localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2, K_MEMRD = 3,
                 K_MEMWB = 4, K_MEMWR = 5, K_RTEX = 6, K_RTWB = 7,
                 K_BEQ = 8, K_ADDIEX = 9, K_ADDIWB = 10, K_JMP = 11;

  typedef struct packed {
    logic       mem_req;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       illegal_op;
    logic       i_or_d;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } cw_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mc_control_if bus();

  mc_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  cw_t dut_cw;
  assign dut_cw = {bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write,
                   bus.mem_write, bus.branch, bus.illegal_op, bus.i_or_d,
                   bus.alu_src_a, bus.reg_dst, bus.mem_to_reg,
                   bus.alu_src_b, bus.alu_op, bus.pc_src};

  function automatic bit op_known(input logic [5:0] o);
    case (o)
      T_LW, T_SW, T_RT, T_BEQ, T_J: return 1'b1;
`ifdef MC_ADDI_SUPPORT_EN
      T_ADDI: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // What the datapath must see during a given instruction step
  function automatic cw_t model_word(input int k, input logic [5:0] o,
                                     input logic mr, input logic rs);
    cw_t c;
    c = '0;
    if (rs) begin
      c.alu_src_b = 2'b01;
      return c;
    end
    case (k)
      K_FETCH:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      K_DECODE: begin c.alu_src_b = 2'b11; c.illegal_op = !op_known(o); end
      K_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      K_MEMRD:  begin c.mem_req = 1; c.i_or_d = 1; end
      K_MEMWB:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      K_MEMWR:  begin c.mem_req = 1; c.i_or_d = 1; c.mem_write = 1; end
      K_RTEX:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      K_RTWB:   begin c.reg_dst = 1; c.reg_write = 1; end
      K_BEQ:    begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1; end
      K_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      K_ADDIWB: begin c.reg_write = 1; end
      K_JMP:    begin c.pc_src = 2'b10; c.pc_write = 1; end
      default:  ;
    endcase
    return c;
  endfunction

  // Model + per-cycle compare; inputs are stable from negedge to posedge
  initial begin
    int  cur;
    int  plan[$];
    cw_t exp_cw;
    bit  adv;
    cur = K_FETCH;
    forever begin
      @(negedge clk);
      exp_cw = model_word(cur, bus.op, bus.mem_ready, reset);
      checks++;
      if (dut_cw !== exp_cw) begin
        failures++;
        $display("FAIL model_cmp t=%0t step=%0d op=%b mr=%b rst=%b actual=%h expected=%h",
                 $time, cur, bus.op, bus.mem_ready, reset, dut_cw, exp_cw);
      end
      if (reset) begin
        cur = K_FETCH;
        plan.delete();
      end else begin
        adv = !((cur == K_FETCH || cur == K_MEMRD || cur == K_MEMWR) && !bus.mem_ready);
        if (adv) begin
          case (cur)
            K_FETCH: plan.push_back(K_DECODE);
            K_DECODE: begin
              case (bus.op)
                T_LW, T_SW: plan.push_back(K_MEMADR);
                T_RT:  begin plan.push_back(K_RTEX); plan.push_back(K_RTWB); end
                T_BEQ: plan.push_back(K_BEQ);
                T_J:   plan.push_back(K_JMP);
`ifdef MC_ADDI_SUPPORT_EN
                T_ADDI: begin plan.push_back(K_ADDIEX); plan.push_back(K_ADDIWB); end
`endif
                default: ;
              endcase
            end
            K_MEMADR: begin
              if (bus.op == T_LW) begin
                plan.push_back(K_MEMRD);
                plan.push_back(K_MEMWB);
              end else begin
                plan.push_back(K_MEMWR);
              end
            end
            default: ;
          endcase
          cur = (plan.size() > 0) ? plan.pop_front() : K_FETCH;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive just after posedge, return at the following negedge
  task automatic cyc(input logic r, input logic [5:0] o, input logic m);
    @(posedge clk);
    #1;
    reset = r;
    bus.op = o;
    bus.mem_ready = m;
    @(negedge clk);
  endtask

  initial begin
    logic       r;
    logic [5:0] o;
    logic       m;
    reset = 1'b1;
    bus.op = 6'b0;
    bus.mem_ready = 1'b0;

    // Reset state: strobes low even with mem_ready high, FETCH selects shown
    cyc(1, 6'd0, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_ir_write", bus.ir_write, 0);
    chk("rst_pc_write", bus.pc_write, 0);
    chk("rst_alu_src_b", bus.alu_src_b, 1);

    // lw with no stalls
    cyc(0, T_LW, 1);
    chk("lw_c1_mem_req", bus.mem_req, 1);
    chk("lw_c1_ir_write", bus.ir_write, 1);
    chk("lw_c1_reg_write", bus.reg_write, 0);
    cyc(0, T_LW, 1);
    chk("lw_c2_alu_src_b", bus.alu_src_b, 3);
    chk("lw_c2_illegal", bus.illegal_op, 0);
    cyc(0, T_LW, 1);
    chk("lw_c3_alu_src_a", bus.alu_src_a, 1);
    chk("lw_c3_alu_src_b", bus.alu_src_b, 2);
    cyc(0, T_LW, 1);
    chk("lw_c4_i_or_d", bus.i_or_d, 1);
    chk("lw_c4_reg_write", bus.reg_write, 0);
    cyc(0, T_LW, 1);
    chk("lw_c5_reg_write", bus.reg_write, 1);
    chk("lw_c5_mem_to_reg", bus.mem_to_reg, 1);

    // FETCH stalled three cycles, then beq
    for (int i = 0; i < 3; i++) begin
      cyc(0, 6'd0, 0);
      chk("stall_mem_req", bus.mem_req, 1);
      chk("stall_ir_write", bus.ir_write, 0);
      chk("stall_pc_write", bus.pc_write, 0);
    end
    cyc(0, T_BEQ, 1);
    chk("stall_c4_ir_write", bus.ir_write, 1);
    chk("stall_c4_pc_write", bus.pc_write, 1);
    cyc(0, T_BEQ, 1);
    cyc(0, T_LW, 1);
    chk("beq_alu_op", bus.alu_op, 1);
    chk("beq_pc_src", bus.pc_src, 1);
    chk("beq_branch", bus.branch, 1);

    // Unrecognised opcode
    cyc(0, T_BAD, 1);
    chk("beq_done_fetch", bus.mem_req, 1);
    cyc(0, T_BAD, 1);
    chk("bad_illegal", bus.illegal_op, 1);
    chk("bad_reg_write", bus.reg_write, 0);
    chk("bad_pc_write", bus.pc_write, 0);
    chk("bad_mem_write", bus.mem_write, 0);
    cyc(0, T_SW, 1);
    chk("bad_next_fetch", bus.mem_req, 1);
    chk("bad_one_cycle", bus.illegal_op, 0);

    // sw stalled in MEMWR, then reset mid-stall
    cyc(0, T_SW, 1);
    cyc(0, T_SW, 1);
    cyc(0, T_LW, 0);
    chk("sw_mem_write", bus.mem_write, 1);
    chk("sw_i_or_d", bus.i_or_d, 1);
    cyc(0, T_LW, 0);
    chk("sw_hold_mem_write", bus.mem_write, 1);
    cyc(1, T_LW, 0);
    chk("sw_rst_mem_write", bus.mem_write, 0);
    chk("sw_rst_mem_req", bus.mem_req, 0);
    cyc(0, T_ADDI, 1);
    chk("sw_rst_fetch_req", bus.mem_req, 1);
    chk("sw_rst_fetch_srcb", bus.alu_src_b, 1);

    // addi with and without support
    cyc(0, T_ADDI, 1);
`ifdef MC_ADDI_SUPPORT_EN
    chk("addi_illegal", bus.illegal_op, 0);
    cyc(0, T_ADDI, 1);
    chk("addi_ex_srca", bus.alu_src_a, 1);
    chk("addi_ex_srcb", bus.alu_src_b, 2);
    cyc(0, T_ADDI, 1);
    chk("addi_wb_reg_write", bus.reg_write, 1);
    cyc(0, T_J, 1);
    chk("addi_done_fetch", bus.mem_req, 1);
`else
    chk("addi_illegal", bus.illegal_op, 1);
    cyc(0, T_J, 1);
    chk("addi_back_fetch", bus.mem_req, 1);
    chk("addi_no_ex", bus.alu_src_a, 0);
`endif

    // jump
    cyc(0, T_J, 1);
    cyc(0, T_J, 1);
    chk("j_pc_src", bus.pc_src, 2);
    chk("j_pc_write", bus.pc_write, 1);
    chk("j_mem_req", bus.mem_req, 0);

    // Randomized traffic, checked by the model process
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 7))
        0: o = T_LW;
        1: o = T_SW;
        2: o = T_RT;
        3: o = T_BEQ;
        4: o = T_J;
        5: o = T_ADDI;
        6: o = T_LW;
        default: o = 6'($urandom_range(0, 63));
      endcase
      m = ($urandom_range(0, 3) != 0);
      cyc(r, o, m);
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
